pdm_frontend: RTL and testbench
===============================

Name: pdm_frontend

Overview:
- Microphone front end that sits directly upstream of the clap detector.
- Generates the PDM microphone clock and channel select, samples the 1-bit PDM stream, and decimates it by counting ones over a fixed window.
- Emits one unsigned PCM sample plus one amplitude value per window, qualified by a single-cycle valid strobe.
- Downstream clap detection then works on amplitude samples instead of raw PDM bits.

Parameters:
- CLK_HALF, 25: clk_i cycles per M_CLK half-period. 100 MHz / 50 gives a 2 MHz M_CLK.
- DECIM, 64: PDM bits per output sample. Must be even and ≥ 2.
- SAMPLE_W, 7: output width. Must satisfy 2^SAMPLE_W > DECIM.

Ports:
- clk_i  in  1  system clock, 100 MHz
- rst_i  in  1  synchronous reset, active-high
- en_i  in  1  run enable
- m_data_i  in  1  raw PDM data from the microphone (asynchronous to clk_i)
- m_clk_o  out  1  PDM microphone clock
- m_lrsel_o  out  1  microphone channel select
- sample_o  out  SAMPLE_W  ones count of the last completed window, 0..DECIM
- amp_o  out  SAMPLE_W  |2*sample - DECIM|, 0..DECIM
- sample_valid_o  out  1  one-cycle strobe when sample_o and amp_o update

Behaviour:
- Clock domain and reset:
  - Single clock clk_i. All state is updated on the rising edge.
  - Reset is synchronous and active-high on rst_i. Reset has priority over everything else.
- Reset values:
  - m_clk_o=0, m_lrsel_o=0, sample_o=0, amp_o=0, sample_valid_o=0.
  - Half-period counter, bit counter, ones accumulator and both sync flops are cleared.
- m_lrsel_o: tied to 0 at all times (left channel).
- Input synchronizer: m_data_i passes through a 2-flop synchronizer. Only the second flop (d_s) is used.
- Clock generation:
  - Half-period counter hc counts 0..CLK_HALF-1.
  - When hc==CLK_HALF-1: hc wraps to 0 and m_clk_o toggles. Result: M_CLK high CLK_HALF cycles, low CLK_HALF cycles.
- Bit sampling:
  - A bit strobe fires in the cycle where hc==CLK_HALF-1 and m_clk_o==1, i.e. the cycle that drives the falling edge.
  - At a strobe, d_s is taken as the PDM bit. Exactly one bit per M_CLK period.
- Accumulation:
  - Bit counter bc counts 0..DECIM-1. Accumulator acc has SAMPLE_W bits.
  - On a strobe with bc<DECIM-1: acc += bit, bc += 1.
  - On a strobe with bc==DECIM-1 (window close): sample_o <= acc+bit; amp_o <= |2*(acc+bit) - DECIM|, computed at SAMPLE_W+1 bits internally; sample_valid_o <= 1 for exactly one cycle; acc <= 0; bc <= 0.
  - sample_o and amp_o hold their values between strobes.
- Latency: sample_valid_o asserts 1 clk_i cycle after the strobe that samples the DECIM-th bit.
- Window period: DECIM*2*CLK_HALF clk_i cycles, i.e. 3200 cycles (31.25 kHz) by default.
- Enable, en_i=0:
  - m_clk_o is forced to 0; hc, bc and acc are cleared; no strobes and no valid.
  - sample_o and amp_o hold their last values.
  - A partial window in progress when en_i falls is discarded.
- Enable, en_i rising:
  - Generation restarts from hc=0 with m_clk_o low.
  - The first sampled bit occurs 2*CLK_HALF cycles after en_i is seen high.
  - The first window contains only bits sampled after re-enable.
- Reset mid-window: the partial window is discarded, with the same effect as en_i low.
- Boundaries:
  - All-ones window gives sample=DECIM, amp=DECIM.
  - All-zeros window gives sample=0, amp=DECIM.
  - Balanced window gives sample=DECIM/2, amp=0.
  - No overflow is possible because 2^SAMPLE_W > DECIM.
- Simultaneous events:
  - rst_i beats en_i.
  - The window-close update and the acc clear take place in the same cycle; no bit is lost across windows.

Test Plan:
- Reset: rst_i=1 for 3 cycles, m_data_i toggling → all outputs 0, m_clk_o stays 0 throughout.
- Clock: en_i=1 for 500 cycles → m_clk_o toggles every 25 cycles (period 50, 50% duty); m_lrsel_o=0 throughout.
- Constant data:
  - m_data_i=1 continuously → first valid ≈3200 cycles after enable; sample_o=64, amp_o=64, valid pulse exactly 1 cycle wide, repeats every 3200 cycles.
  - m_data_i=0 continuously → sample_o=0, amp_o=64.
- Patterned data, driven synchronous to m_clk_o falling edges:
  - Alternating 1/0 → sample_o=32, amp_o=0.
  - 48 ones then 16 zeros → sample_o=48, amp_o=32.
- Enable drop: en_i=0 after 40 bits of all-ones, hold 100 cycles, re-enable with m_data_i=0 → no valid during the gap; next window sample_o=0 (no carry-over of the 40 ones); m_clk_o low during the gap.
- Reset mid-window: rst_i pulse after 20 ones, then all-ones input → next valid arrives 3200 cycles after reset release, plus up to 2 cycles of sync, with sample_o=64.

Source files
------------

// File: rtl/pdm_frontend.sv
// PDM microphone front end: generates M_CLK, samples the 1-bit stream once per
// M_CLK period and decimates it by counting ones over a DECIM-bit window.
module pdm_frontend #(
  parameter int CLK_HALF = 25,
  parameter int DECIM    = 64,
  parameter int SAMPLE_W = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                m_data_i,
  output logic                m_clk_o,
  output logic                m_lrsel_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic [SAMPLE_W-1:0] amp_o,
  output logic                sample_valid_o
);

  localparam int HC_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int BC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [HC_W-1:0]     HC_LAST = HC_W'(CLK_HALF - 1);
  localparam logic [BC_W-1:0]     BC_LAST = BC_W'(DECIM - 1);
  localparam logic [SAMPLE_W:0]   DECIM_X = (SAMPLE_W + 1)'(DECIM);

  logic                data_meta;
  logic                d_s;
  logic [HC_W-1:0]     hc;
  logic [BC_W-1:0]     bc;
  logic [SAMPLE_W-1:0] acc;

  logic                strobe;
  logic [SAMPLE_W-1:0] total;
  logic [SAMPLE_W:0]   twice;
  logic [SAMPLE_W:0]   amp_full;
  logic                unused_amp_msb;

  assign m_lrsel_o = 1'b0;

  // The strobe lands on the cycle that drives M_CLK low, so the mic's data
  // (launched on the rising edge) has had half a period to settle.
  assign strobe = en_i && (hc == HC_LAST) && m_clk_o;

  // Window total including the bit sampled this cycle; fits SAMPLE_W since
  // 2^SAMPLE_W > DECIM.
  always_comb begin
    total    = acc + SAMPLE_W'(d_s);
    twice    = {total, 1'b0};
    amp_full = (twice >= DECIM_X) ? (twice - DECIM_X) : (DECIM_X - twice);
  end

  assign unused_amp_msb = amp_full[SAMPLE_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_meta      <= 1'b0;
      d_s            <= 1'b0;
      hc             <= '0;
      bc             <= '0;
      acc            <= '0;
      m_clk_o        <= 1'b0;
      sample_o       <= '0;
      amp_o          <= '0;
      sample_valid_o <= 1'b0;
    end else begin
      data_meta      <= m_data_i;
      d_s            <= data_meta;
      sample_valid_o <= 1'b0;
      if (!en_i) begin
        // Idle: park M_CLK low and drop any partial window.
        hc      <= '0;
        bc      <= '0;
        acc     <= '0;
        m_clk_o <= 1'b0;
      end else begin
        if (hc == HC_LAST) begin
          hc      <= '0;
          m_clk_o <= ~m_clk_o;
        end else begin
          hc <= hc + 1'b1;
        end
        if (strobe) begin
          if (bc == BC_LAST) begin
            sample_o       <= total;
            amp_o          <= amp_full[SAMPLE_W-1:0];
            sample_valid_o <= 1'b1;
            acc            <= '0;
            bc             <= '0;
          end else begin
            acc <= total;
            bc  <= bc + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_frontend.sv
// Self-checking bench for pdm_frontend: drives PDM bits aligned to the M_CLK
// timeline and compares every cycle against a window-level reference model.
module tb_pdm_frontend;

  localparam int CLK_HALF = 25;
  localparam int DECIM    = 64;
  localparam int SAMPLE_W = 7;
  localparam int BIT_PER  = 2 * CLK_HALF;
  localparam int WIN      = DECIM * BIT_PER;

  logic                clk = 1'b0;
  logic                rst_i;
  logic                en_i;
  logic                m_data_i;
  logic                m_clk_o;
  logic                m_lrsel_o;
  logic [SAMPLE_W-1:0] sample_o;
  logic [SAMPLE_W-1:0] amp_o;
  logic                sample_valid_o;

  pdm_frontend #(
    .CLK_HALF(CLK_HALF),
    .DECIM   (DECIM),
    .SAMPLE_W(SAMPLE_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .m_data_i      (m_data_i),
    .m_clk_o       (m_clk_o),
    .m_lrsel_o     (m_lrsel_o),
    .sample_o      (sample_o),
    .amp_o         (amp_o),
    .sample_valid_o(sample_valid_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: n = rising edges seen since enable (-1 while idle)
  int       n          = -1;
  int       kidx       = 0;
  int       mode       = 0;
  int       exp_sample = 0;
  int       exp_amp    = 0;
  int       valid_cnt  = 0;
  bit       exp_valid  = 1'b0;
  bit       win_q[$];

  function automatic bit gen_bit(input int m, input int k);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k % 2) == 0;
      3:       return (k % DECIM) < 48;
      default: return bit'($urandom_range(0, 1));
    endcase
  endfunction

  // driver: one clk cycle with the given enable/reset levels
  task automatic cycle(input bit en, input bit rst);
    int s;
    bit b;
    en_i  = en;
    rst_i = rst;
    @(posedge clk);
    exp_valid = 1'b0;
    if (rst) begin
      n = -1;
      kidx = 0;
      win_q.delete();
      exp_sample = 0;
      exp_amp = 0;
    end else if (!en) begin
      n = -1;
      kidx = 0;
      win_q.delete();
    end else begin
      n++;
      if (n % WIN == WIN - 1) begin
        s = 0;
        for (int i = 0; i < DECIM; i++) s += int'(win_q.pop_front());
        exp_sample = s;
        exp_amp = (2 * s >= DECIM) ? 2 * s - DECIM : DECIM - 2 * s;
        exp_valid = 1'b1;
        valid_cnt++;
      end
    end
    @(negedge clk);
    check("m_clk", 32'(m_clk_o), (n < 0) ? 0 : ((n + 1) / CLK_HALF) % 2);
    check("m_lrsel", 32'(m_lrsel_o), 0);
    check("valid", 32'(sample_valid_o), 32'(exp_valid));
    check("sample", 32'(sample_o), exp_sample);
    check("amp", 32'(amp_o), exp_amp);
    // New bit presented on the M_CLK rising edge, held for a full period.
    if (n >= 0 && (n % BIT_PER) == CLK_HALF - 1) begin
      b = gen_bit(mode, kidx);
      win_q.push_back(b);
      kidx++;
      m_data_i = b;
    end else if (n < 0) begin
      m_data_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run(input int m, input int cyc);
    mode = m;
    repeat (3) cycle(1'b0, 1'b0);
    repeat (cyc) cycle(1'b1, 1'b0);
  endtask

  initial begin
    int v0;
    m_data_i = 1'b0;
    en_i     = 1'b0;
    rst_i    = 1'b1;
    repeat (3) cycle(1'b0, 1'b1);

    run(1, 2 * WIN + 10);  // all ones, two windows
    run(0, WIN + 10);      // all zeros
    run(2, WIN + 10);      // alternating
    run(3, WIN + 10);      // 48 ones, 16 zeros
    run(4, 3 * WIN + 10);  // random

    // enable drop after 40 ones; next window must not carry them
    mode = 1;
    repeat (40 * BIT_PER + 10) cycle(1'b1, 1'b0);
    v0 = valid_cnt;
    repeat (100) cycle(1'b0, 1'b0);
    check("gap_no_valid", 32'(valid_cnt - v0), 0);
    mode = 0;
    repeat (WIN + 10) cycle(1'b1, 1'b0);
    check("drop_sample", 32'(sample_o), 0);

    // reset mid-window after 20 ones, then all ones
    run(1, 20 * BIT_PER + 10);
    repeat (2) cycle(1'b1, 1'b1);
    repeat (WIN + 10) cycle(1'b1, 1'b0);
    check("rst_mid_sample", 32'(sample_o), DECIM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
